// File: rtl/nms_window_ctrl.sv
// nms_window_ctrl: raster sequencer for the 3x3 NMS window (line-buffer shift, window valid/centre, frame status)
module nms_window_ctrl #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 636,
  parameter int CW = 10,
  parameter int RW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          in_valid,
  output logic          lb_shift_en,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_abort,
  output logic          err_stray
);
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, win_col_q, win_col_d, c;
  logic [RW-1:0] row_q, row_d, win_row_q, win_row_d, r;
  logic win_valid_q, win_valid_d, frame_done_q, frame_done_d, err_stray_q, err_stray_d;
  logic active, restart, acc, wrap, last, win_hit;
  always_comb begin
    active = state_q == PRIME || state_q == STREAM;
    restart = frame_start && active;
    c = frame_start ? '0 : col_q;
    r = frame_start ? '0 : row_q;
    acc = in_valid && active;
    wrap = c == CW'(IMG_W - 1);
    last = wrap && r == RW'(IMG_H - 1);
    win_hit = acc && r >= RW'(2) && c >= CW'(2);
    col_d = acc ? (wrap ? '0 : c + CW'(1)) : c;
    row_d = acc ? (last ? '0 : wrap ? r + RW'(1) : r) : r;
    state_d = frame_start && state_q != STREAM && state_q != PRIME ? PRIME :
              restart ? (acc && last ? DONE : PRIME) :
              state_q == IDLE || state_q == DONE ? IDLE :
              acc && last ? DONE :
              state_q == PRIME && acc && r == RW'(2) && c == CW'(2) ? STREAM : state_q;
    win_valid_d = win_hit;
    win_col_d = win_hit ? c - CW'(1) : win_col_q;
    win_row_d = win_hit ? r - RW'(1) : win_row_q;
    frame_done_d = state_q == DONE;
    err_stray_d = in_valid && state_q == IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      win_valid_q <= 1'b0;
      win_col_q <= '0;
      win_row_q <= '0;
      frame_done_q <= 1'b0;
      err_stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      win_valid_q <= win_valid_d;
      win_col_q <= win_col_d;
      win_row_q <= win_row_d;
      frame_done_q <= frame_done_d;
      err_stray_q <= err_stray_d;
    end
  end
  assign lb_shift_en = acc;
  assign win_valid = win_valid_q;
  assign win_col = win_col_q;
  assign win_row = win_row_q;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign frame_abort = restart;
  assign err_stray = err_stray_q;
endmodule

// File: tb/tb_nms_window_ctrl.sv
// tb_nms_window_ctrl: directed self-checking bench for nms_window_ctrl (8x5 frame)
module tb_nms_window_ctrl;
  localparam int W = 8;
  localparam int H = 5;
  localparam int NWIN = (W - 2) * (H - 2);
  logic clk = 1'b0;
  logic rst, frame_start, in_valid;
  logic lb_shift_en, win_valid, busy, frame_done, frame_abort, err_stray;
  logic [3:0] win_col, win_row;
  int n_cmp = 0, n_err = 0;
  int acc_cnt = 0, frame_wins = 0, done_cnt = 0, stray_cnt = 0, shift_cnt = 0, abort_cnt = 0;
  bit prev_acc = 1'b0, prev_win = 1'b0;
  nms_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(4), .RW(4)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
    .lb_shift_en(lb_shift_en), .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort), .err_stray(err_stray)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      acc_cnt = 0;
      frame_wins = 0;
      prev_acc = 1'b0;
      prev_win = 1'b0;
    end else begin
      if (win_valid) begin
        chk("win_after_accept", 32'(prev_acc), 1);
        chk("win_row_vs_pixel", 32'(win_row), (acc_cnt - 1) / W - 1);
        chk("win_col_vs_pixel", 32'(win_col), (acc_cnt - 1) % W - 1);
        chk("win_row_order", 32'(win_row), frame_wins / (W - 2) + 1);
        chk("win_col_order", 32'(win_col), frame_wins % (W - 2) + 1);
        frame_wins++;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_after_last_win", 32'(prev_win), 1);
        chk("done_win_count", frame_wins, NWIN);
      end
      if (err_stray) stray_cnt++;
      if (frame_abort) abort_cnt++;
      if (frame_start) begin
        acc_cnt = 0;
        frame_wins = 0;
      end
      if (lb_shift_en) begin
        acc_cnt++;
        shift_cnt++;
      end
      prev_acc = lb_shift_en;
      prev_win = win_valid;
    end
  end
  task automatic cyc(input bit fs, input bit v);
    @(posedge clk);
    #1;
    frame_start = fs;
    in_valid = v;
  endtask
  task automatic pixels(input int n, input bit gaps);
    int sent = 0, k = 0;
    while (sent < n && k < 2000) begin
      bit v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(0, v);
      sent += int'(v);
      k++;
    end
    if (sent < n) chk("pixel_budget", sent, n);
  endtask
  task automatic tail();
    repeat (3) cyc(0, 0);
    @(negedge clk);
  endtask
  task automatic frame(input string tag, input bit gaps);
    int d0 = done_cnt, s0 = shift_cnt;
    cyc(1, 0);
    pixels(40, gaps);
    tail();
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_wins"}, frame_wins, NWIN);
    chk({tag, "_shifts"}, shift_cnt - s0, 40);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask
  initial begin
    int d0, s0, a0;
    rst = 1'b1;
    frame_start = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {win_valid, win_col, win_row, busy, frame_done, frame_abort, err_stray, lb_shift_en}, 0);
    cyc(0, 0);
    rst = 1'b0;
    tail();
    frame("t1", 1'b0);
    frame("t2", 1'b1);
    cyc(1, 0);
    pixels(24, 1'b0);
    cyc(0, 1);
    cyc(0, 1);
    @(negedge clk);
    chk("t3_col0_nowin", 32'(win_valid), 0);
    cyc(0, 1);
    @(negedge clk);
    chk("t3_col1_nowin", 32'(win_valid), 0);
    cyc(0, 0);
    @(negedge clk);
    chk("t3_col2_win", {win_valid, win_row, win_col}, {1'b1, 4'd2, 4'd1});
    pixels(13, 1'b0);
    tail();
    chk("t3_wins", frame_wins, NWIN);
    a0 = abort_cnt;
    d0 = done_cnt;
    cyc(1, 0);
    pixels(20, 1'b0);
    cyc(1, 0);
    @(negedge clk);
    chk("t4_abort", 32'(frame_abort), 1);
    pixels(40, 1'b0);
    tail();
    chk("t4_abort_count", abort_cnt - a0, 1);
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_wins", frame_wins, NWIN);
    s0 = stray_cnt;
    d0 = shift_cnt;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1);
      @(negedge clk);
      chk("t5_no_shift", 32'(lb_shift_en), 0);
      chk("t5_idle", 32'(busy), 0);
    end
    tail();
    chk("t5_strays", stray_cnt - s0, 3);
    chk("t5_shifts", shift_cnt - d0, 0);
    frame("t5_next", 1'b0);
    cyc(1, 0);
    pixels(25, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(0, 1);
    @(negedge clk);
    chk("t6_reset_outs", {win_valid, win_col, win_row, busy, frame_done, frame_abort, err_stray, lb_shift_en}, 0);
    cyc(0, 0);
    rst = 1'b0;
    tail();
    frame("t6_next", 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
